// File: rtl/processor.sv
// Five-stage in-order MIPS-subset pipeline (IF/ID/EX/MEM/WB) with precise exceptions.
// Optional macro FORWARDING_EN: EX-stage operand forwarding; otherwise ID interlocks on every RAW hazard.
module processor #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst,
  output logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_wr,
  output logic [31:0] PC_IF_ID,
  output logic [31:0] PC_ID_EX,
  output logic [31:0] PC_EX_MEM,
  output logic [31:0] PC_MEM_WB,
  output logic [31:0] EPC,
  output logic        exception,
  output logic        cause
);
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4;

  typedef struct packed {
    logic       wr, mrd, mwr, imm, br, jmp, ill, ovf;
    logic [2:0] alu;
    logic [4:0] dst;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d = '0;
    case (w[31:26])
      6'h00: begin
        if (w != 32'h0) begin
          d.wr  = 1'b1;
          d.dst = w[15:11];
          case (w[5:0])
            6'h20:   begin d.alu = ALU_ADD; d.ovf = 1'b1; end
            6'h22:   begin d.alu = ALU_SUB; d.ovf = 1'b1; end
            6'h24:   d.alu = ALU_AND;
            6'h25:   d.alu = ALU_OR;
            6'h2A:   d.alu = ALU_SLT;
            default: begin d.ill = 1'b1; d.wr = 1'b0; end
          endcase
        end else begin
          d.wr = 1'b0;
        end
      end
      6'h08:   begin d.wr = 1'b1; d.dst = w[20:16]; d.imm = 1'b1; d.ovf = 1'b1; end
      6'h23:   begin d.wr = 1'b1; d.dst = w[20:16]; d.imm = 1'b1; d.mrd = 1'b1; end
      6'h2B:   begin d.imm = 1'b1; d.mwr = 1'b1; end
      6'h04:   d.br = 1'b1;
      6'h02:   d.jmp = 1'b1;
      default: d.ill = 1'b1;
    endcase
    d.wr = d.wr & (d.dst != 5'd0);
    return d;
  endfunction

  // Source-register usage {rs, rt}; only ID needs this for interlocks.
  function automatic logic [1:0] src_use(input logic [31:0] w);
    case (w[31:26])
      6'h00:        src_use = (w != 32'h0) ? 2'b11 : 2'b00;
      6'h08, 6'h23: src_use = 2'b10;
      6'h2B, 6'h04: src_use = 2'b11;
      default:      src_use = 2'b00;
    endcase
  endfunction

  function automatic logic hit(input logic wr, input logic [4:0] dst, input logic [1:0] u,
                               input logic [4:0] rs, input logic [4:0] rt);
    return wr && ((u[1] && dst == rs) || (u[0] && dst == rt));
  endfunction

  logic [31:0] pc_q, pc_d, ifid_inst_q, ifid_inst_d, ifid_pc_q, ifid_pc_d;
  logic [31:0] idex_inst_q, idex_inst_d, idex_pc_q, idex_pc_d, idex_a_q, idex_a_d, idex_b_q, idex_b_d;
  logic [31:0] exmem_pc_q, exmem_pc_d, exmem_res_q, exmem_res_d, exmem_sd_q, exmem_sd_d;
  logic [4:0]  exmem_dst_q, exmem_dst_d, memwb_dst_q, memwb_dst_d;
  logic        exmem_wr_q, exmem_wr_d, exmem_mrd_q, exmem_mrd_d, exmem_mwr_q, exmem_mwr_d;
  logic [31:0] memwb_pc_q, memwb_pc_d, memwb_val_q, memwb_val_d, epc_q, epc_d;
  logic        memwb_wr_q, memwb_wr_d, cause_q, cause_d;
  logic [31:0] rf_q [32];

  logic [1:0]  id_use;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_a, id_b;
  logic        stall;
  dec_t        ex_dec;
  logic [31:0] fwd_a, fwd_b, simm, op_b, sum, diff, ex_res, pc4, target;
  logic        ex_ovf, ex_exc, taken;

  // ID: register read with write-through from WB.
  always_comb begin
    id_use = src_use(ifid_inst_q);
    id_rs  = ifid_inst_q[25:21];
    id_rt  = ifid_inst_q[20:16];
    id_a   = (memwb_wr_q && memwb_dst_q == id_rs) ? memwb_val_q : rf_q[id_rs];
    id_b   = (memwb_wr_q && memwb_dst_q == id_rt) ? memwb_val_q : rf_q[id_rt];
  end

  // ID interlock: load-use only when forwarding exists, every pending writer otherwise.
  always_comb begin
`ifdef FORWARDING_EN
    stall = ex_dec.mrd && hit(ex_dec.wr, ex_dec.dst, id_use, id_rs, id_rt);
`else
    stall = hit(ex_dec.wr, ex_dec.dst, id_use, id_rs, id_rt)
          || hit(exmem_wr_q, exmem_dst_q, id_use, id_rs, id_rt)
          || hit(memwb_wr_q, memwb_dst_q, id_use, id_rs, id_rt);
`endif
  end

  // EX: operand selection, ALU, overflow/illegal detection, branch resolution.
  always_comb begin
    ex_dec = decode(idex_inst_q);
    fwd_a  = idex_a_q;
    fwd_b  = idex_b_q;
`ifdef FORWARDING_EN
    if (exmem_wr_q && exmem_dst_q == idex_inst_q[25:21]) fwd_a = exmem_res_q;
    else if (memwb_wr_q && memwb_dst_q == idex_inst_q[25:21]) fwd_a = memwb_val_q;
    else fwd_a = idex_a_q;
    if (exmem_wr_q && exmem_dst_q == idex_inst_q[20:16]) fwd_b = exmem_res_q;
    else if (memwb_wr_q && memwb_dst_q == idex_inst_q[20:16]) fwd_b = memwb_val_q;
    else fwd_b = idex_b_q;
`endif
    simm = {{16{idex_inst_q[15]}}, idex_inst_q[15:0]};
    op_b = ex_dec.imm ? simm : fwd_b;
    sum  = fwd_a + op_b;
    diff = fwd_a - op_b;
    case (ex_dec.alu)
      ALU_ADD: ex_res = sum;
      ALU_SUB: ex_res = diff;
      ALU_AND: ex_res = fwd_a & op_b;
      ALU_OR:  ex_res = fwd_a | op_b;
      ALU_SLT: ex_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
      default: ex_res = sum;
    endcase
    ex_ovf = ex_dec.ovf && ((ex_dec.alu == ALU_ADD)
             ? (fwd_a[31] == op_b[31] && sum[31] != fwd_a[31])
             : (fwd_a[31] != op_b[31] && diff[31] != fwd_a[31]));
    ex_exc = ex_dec.ill | ex_ovf;
    pc4    = idex_pc_q + 32'd4;
    taken  = ex_dec.jmp | (ex_dec.br & (fwd_a == fwd_b));
    target = ex_dec.jmp ? {pc4[31:28], idex_inst_q[25:0], 2'b00} : pc4 + (simm << 2);
  end

  // Next-state: exception beats taken branch beats stall.
  always_comb begin
    pc_d        = pc_q + 32'd4;
    ifid_inst_d = inst;          ifid_pc_d = pc_q;
    idex_inst_d = ifid_inst_q;   idex_pc_d = ifid_pc_q;
    idex_a_d    = id_a;          idex_b_d  = id_b;
    exmem_pc_d  = idex_pc_q;     exmem_res_d = ex_res;   exmem_sd_d = fwd_b;
    exmem_dst_d = ex_dec.dst;    exmem_wr_d  = ex_dec.wr;
    exmem_mrd_d = ex_dec.mrd;    exmem_mwr_d = ex_dec.mwr;
    memwb_pc_d  = exmem_pc_q;    memwb_val_d = exmem_mrd_q ? data_in : exmem_res_q;
    memwb_dst_d = exmem_dst_q;   memwb_wr_d  = exmem_wr_q;
    epc_d       = epc_q;         cause_d     = cause_q;
    if (ex_exc) begin
      pc_d        = HANDLER_ADDR;
      ifid_inst_d = 32'h0;  ifid_pc_d = 32'h0;
      idex_inst_d = 32'h0;  idex_pc_d = 32'h0;  idex_a_d = 32'h0;  idex_b_d = 32'h0;
      exmem_pc_d  = 32'h0;  exmem_res_d = 32'h0;  exmem_sd_d = 32'h0;  exmem_dst_d = 5'd0;
      exmem_wr_d  = 1'b0;   exmem_mrd_d = 1'b0;   exmem_mwr_d = 1'b0;
      epc_d       = idex_pc_q;
      cause_d     = ex_ovf;
    end else if (taken) begin
      pc_d        = target;
      ifid_inst_d = 32'h0;  ifid_pc_d = 32'h0;
      idex_inst_d = 32'h0;  idex_pc_d = 32'h0;  idex_a_d = 32'h0;  idex_b_d = 32'h0;
    end else if (stall) begin
      pc_d        = pc_q;
      ifid_inst_d = ifid_inst_q;  ifid_pc_d = ifid_pc_q;
      idex_inst_d = 32'h0;  idex_pc_d = 32'h0;  idex_a_d = 32'h0;  idex_b_d = 32'h0;
    end else begin
      pc_d        = pc_q + 32'd4;
    end
  end

  // Pipeline and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 32'h0;  ifid_inst_q <= 32'h0;  ifid_pc_q <= 32'h0;
      idex_inst_q <= 32'h0;  idex_pc_q <= 32'h0;  idex_a_q <= 32'h0;  idex_b_q <= 32'h0;
      exmem_pc_q <= 32'h0;  exmem_res_q <= 32'h0;  exmem_sd_q <= 32'h0;  exmem_dst_q <= 5'd0;
      exmem_wr_q <= 1'b0;  exmem_mrd_q <= 1'b0;  exmem_mwr_q <= 1'b0;
      memwb_pc_q <= 32'h0;  memwb_val_q <= 32'h0;  memwb_dst_q <= 5'd0;  memwb_wr_q <= 1'b0;
      epc_q <= 32'h0;  cause_q <= 1'b0;
    end else begin
      pc_q <= pc_d;  ifid_inst_q <= ifid_inst_d;  ifid_pc_q <= ifid_pc_d;
      idex_inst_q <= idex_inst_d;  idex_pc_q <= idex_pc_d;  idex_a_q <= idex_a_d;  idex_b_q <= idex_b_d;
      exmem_pc_q <= exmem_pc_d;  exmem_res_q <= exmem_res_d;  exmem_sd_q <= exmem_sd_d;  exmem_dst_q <= exmem_dst_d;
      exmem_wr_q <= exmem_wr_d;  exmem_mrd_q <= exmem_mrd_d;  exmem_mwr_q <= exmem_mwr_d;
      memwb_pc_q <= memwb_pc_d;  memwb_val_q <= memwb_val_d;  memwb_dst_q <= memwb_dst_d;  memwb_wr_q <= memwb_wr_d;
      epc_q <= epc_d;  cause_q <= cause_d;
    end
  end

  // Register file; $0 is never written because decode clears wr for dst 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (memwb_wr_q) begin
      rf_q[memwb_dst_q] <= memwb_val_q;
    end
  end

  assign inst_addr = pc_q;
  assign data_addr = exmem_res_q;
  assign data_out  = exmem_sd_q;
  assign data_wr   = exmem_mwr_q;
  assign PC_IF_ID  = ifid_pc_q;
  assign PC_ID_EX  = idex_pc_q;
  assign PC_EX_MEM = exmem_pc_q;
  assign PC_MEM_WB = memwb_pc_q;
  assign EPC       = epc_q;
  assign cause     = cause_q;
  assign exception = ex_exc;
endmodule

// File: tb/tb_processor.sv
// Directed bench for processor: small programs in a bench-side memory, results checked via stored words and pipeline PCs.
module tb_processor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_addr, inst, data_addr, data_in, data_out;
  logic        data_wr, exception, cause;
  logic [31:0] PC_IF_ID, PC_ID_EX, PC_EX_MEM, PC_MEM_WB, EPC;

  logic [31:0] imem [0:127];
  logic [31:0] dmem [0:63];
  logic [31:0] dmem_init [0:63];
  int n_checks = 0;
  int n_fail   = 0;
  bit seen;

  processor dut (
    .clk(clk), .rst_n(rst_n), .inst_addr(inst_addr), .inst(inst),
    .data_addr(data_addr), .data_in(data_in), .data_out(data_out), .data_wr(data_wr),
    .PC_IF_ID(PC_IF_ID), .PC_ID_EX(PC_ID_EX), .PC_EX_MEM(PC_EX_MEM), .PC_MEM_WB(PC_MEM_WB),
    .EPC(EPC), .exception(exception), .cause(cause)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (inst_addr[31:9] == 23'd0 && inst_addr[1:0] == 2'd0) inst = imem[inst_addr[8:2]];
    else inst = 32'h0;
    if (data_addr[31:8] == 24'd0 && data_addr[1:0] == 2'd0) data_in = dmem[data_addr[7:2]];
    else data_in = 32'h0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) dmem[i] <= dmem_init[i];
    end else if (data_wr) begin
      dmem[data_addr[7:2]] <= data_out;
    end
  end

  function automatic logic [31:0] f_addi(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {6'h08, rs, rt, imm};
  endfunction
  function automatic logic [31:0] f_lw(input logic [4:0] rt, input logic [15:0] off, input logic [4:0] rs);
    return {6'h23, rs, rt, off};
  endfunction
  function automatic logic [31:0] f_sw(input logic [4:0] rt, input logic [15:0] off, input logic [4:0] rs);
    return {6'h2B, rs, rt, off};
  endfunction
  function automatic logic [31:0] f_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] f_j(input logic [31:0] tgt);
    return {6'h02, tgt[27:2]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check_eq({p, "_inst_addr"}, inst_addr, 32'h0);
    check_eq({p, "_pc_if_id"},  PC_IF_ID, 32'h0);
    check_eq({p, "_pc_id_ex"},  PC_ID_EX, 32'h0);
    check_eq({p, "_pc_ex_mem"}, PC_EX_MEM, 32'h0);
    check_eq({p, "_pc_mem_wb"}, PC_MEM_WB, 32'h0);
    check_eq({p, "_data_wr"},   {31'd0, data_wr}, 32'h0);
    check_eq({p, "_data_addr"}, data_addr, 32'h0);
    check_eq({p, "_exception"}, {31'd0, exception}, 32'h0);
    check_eq({p, "_cause"},     {31'd0, cause}, 32'h0);
    check_eq({p, "_epc"},       EPC, 32'h0);
  endtask

  // Assert reset and wipe program/data images; caller then loads its program.
  task automatic start_prog();
    rst_n = 1'b0;
    for (int i = 0; i < 128; i++) imem[i] = 32'h0;
    for (int i = 0; i < 64; i++) dmem_init[i] = 32'hA5A5_0000 + i;
  endtask

  task automatic go();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_exc(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (exception) found = 1'b1;
    end
  endtask

  task automatic wait_idex(input logic [31:0] pc, input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (PC_ID_EX == pc) found = 1'b1;
    end
  endtask

  initial begin
    start_prog();
    repeat (2) @(negedge clk);
    check_reset("por");

    // ALU program: dependent addi chain, sub/or/slt/and
    start_prog();
    imem[0]  = f_addi(5'd1, 5'd0, 16'd5);
    imem[1]  = f_addi(5'd2, 5'd1, 16'd3);
    imem[2]  = f_sw(5'd2, 16'd0, 5'd0);
    imem[3]  = f_addi(5'd3, 5'd0, 16'hFFFE);
    imem[4]  = f_r(5'd4, 5'd1, 5'd2, 6'h22);
    imem[5]  = f_sw(5'd4, 16'd12, 5'd0);
    imem[6]  = f_r(5'd6, 5'd1, 5'd2, 6'h25);
    imem[7]  = f_sw(5'd6, 16'd16, 5'd0);
    imem[8]  = f_r(5'd7, 5'd3, 5'd1, 6'h2A);
    imem[9]  = f_sw(5'd7, 16'd20, 5'd0);
    imem[10] = f_r(5'd8, 5'd1, 5'd3, 6'h2A);
    imem[11] = f_sw(5'd8, 16'd24, 5'd0);
    imem[12] = f_r(5'd9, 5'd2, 5'd3, 6'h24);
    imem[13] = f_sw(5'd9, 16'd28, 5'd0);
    imem[14] = f_j(32'h38);
    go();
    @(negedge clk);
    check_eq("first_fetch_addr", inst_addr, 32'h4);
    check_eq("first_if_id_pc", PC_IF_ID, 32'h0);
    repeat (90) @(negedge clk);
    check_eq("addi_chain_mem0", dmem[0], 32'h0000_0008);
    check_eq("sub_mem12", dmem[3], 32'hFFFF_FFFD);
    check_eq("or_mem16", dmem[4], 32'h0000_000D);
    check_eq("slt_true_mem20", dmem[5], 32'h0000_0001);
    check_eq("slt_false_mem24", dmem[6], 32'h0000_0000);
    check_eq("and_mem28", dmem[7], 32'h0000_0008);

    // Load-use program
    start_prog();
    dmem_init[1] = 32'h0000_000A;
    imem[1] = f_lw(5'd3, 16'd4, 5'd0);
    imem[2] = f_r(5'd4, 5'd3, 5'd3, 6'h20);
    imem[3] = f_sw(5'd4, 16'd8, 5'd0);
    imem[4] = f_j(32'h10);
    go();
    repeat (4) @(negedge clk);
    check_eq("lu_bubble_id_ex", PC_ID_EX, 32'h0);
    check_eq("lu_hold_if_id", PC_IF_ID, 32'h8);
    check_eq("lu_hold_pc", inst_addr, 32'hC);
    check_eq("lu_lw_in_mem", PC_EX_MEM, 32'h4);
    @(negedge clk);
`ifdef FORWARDING_EN
    check_eq("lu_single_stall", PC_ID_EX, 32'h8);
`else
    check_eq("lu_interlock_more", PC_ID_EX, 32'h0);
`endif
    repeat (30) @(negedge clk);
    check_eq("lw_add_mem8", dmem[2], 32'h0000_0014);

    // Taken branch flushes two slots
    start_prog();
    imem[0] = f_addi(5'd5, 5'd0, 16'd1);
    imem[1] = f_sw(5'd5, 16'd32, 5'd0);
    imem[2] = {6'h04, 5'd0, 5'd0, 16'd2};
    imem[3] = f_addi(5'd5, 5'd0, 16'd7);
    imem[4] = f_addi(5'd5, 5'd0, 16'd9);
    imem[5] = f_sw(5'd5, 16'd36, 5'd0);
    imem[6] = f_j(32'h18);
    go();
    wait_idex(32'h8, 40, seen);
    check_eq("beq_reached_ex", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check_eq("beq_target_fetch", inst_addr, 32'h14);
    check_eq("beq_flush1_id_ex", PC_ID_EX, 32'h0);
    check_eq("beq_flush_if_id", PC_IF_ID, 32'h0);
    @(negedge clk);
    check_eq("beq_flush2_id_ex", PC_ID_EX, 32'h0);
    @(negedge clk);
    check_eq("beq_target_in_ex", PC_ID_EX, 32'h14);
    repeat (20) @(negedge clk);
    check_eq("pre_branch_mem32", dmem[8], 32'h1);
    check_eq("r5_unchanged_mem36", dmem[9], 32'h1);

    // Arithmetic overflow exception
    start_prog();
    imem[0] = f_addi(5'd7, 5'd0, 16'd3);
    imem[1] = f_addi(5'd6, 5'd0, 16'h7FFF);
    for (int i = 2; i < 18; i++) imem[i] = f_r(5'd6, 5'd6, 5'd6, 6'h20);
    imem[18] = f_r(5'd7, 5'd6, 5'd6, 6'h20);
    imem[19] = f_sw(5'd7, 16'd40, 5'd0);
    imem[96] = f_sw(5'd7, 16'd44, 5'd0);
    imem[97] = f_sw(5'd6, 16'd48, 5'd0);
    imem[98] = f_j(32'h188);
    go();
    wait_exc(300, seen);
    check_eq("ovf_exc_seen", {31'd0, seen}, 32'd1);
    check_eq("ovf_pc_in_ex", PC_ID_EX, 32'h48);
    @(negedge clk);
    check_eq("ovf_exc_one_cycle", {31'd0, exception}, 32'd0);
    check_eq("ovf_cause", {31'd0, cause}, 32'd1);
    check_eq("ovf_epc", EPC, 32'h48);
    check_eq("ovf_vector", inst_addr, 32'h180);
    check_eq("ovf_flushed_mem", PC_EX_MEM, 32'h0);
    repeat (20) @(negedge clk);
    check_eq("ovf_r7_unchanged", dmem[11], 32'h3);
    check_eq("ovf_r6_value", dmem[12], 32'h7FFF_0000);
    check_eq("ovf_younger_sw_flushed", dmem[10], 32'hA5A5_000A);

    // One-cycle reset mid-run (cause/EPC nonzero beforehand)
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    for (int i = 0; i < 128; i++) imem[i] = 32'h0;
    imem[0] = f_sw(5'd6, 16'd56, 5'd0);
    imem[1] = f_sw(5'd7, 16'd60, 5'd0);
    imem[2] = f_j(32'h8);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_release_addr", inst_addr, 32'h0);
    @(negedge clk);
    check_eq("midrst_refetch", inst_addr, 32'h4);
    repeat (20) @(negedge clk);
    check_eq("rf_cleared_r6", dmem[14], 32'h0);
    check_eq("rf_cleared_r7", dmem[15], 32'h0);

    // Undefined opcode exception
    start_prog();
    imem[4]  = {6'h3F, 26'h0};
    imem[96] = f_addi(5'd1, 5'd0, 16'h55);
    imem[97] = f_sw(5'd1, 16'd52, 5'd0);
    imem[98] = f_j(32'h188);
    go();
    wait_exc(40, seen);
    check_eq("ill_exc_seen", {31'd0, seen}, 32'd1);
    check_eq("ill_pc_in_ex", PC_ID_EX, 32'h10);
    @(negedge clk);
    check_eq("ill_cause", {31'd0, cause}, 32'd0);
    check_eq("ill_epc", EPC, 32'h10);
    check_eq("ill_vector", inst_addr, 32'h180);
    repeat (20) @(negedge clk);
    check_eq("handler_runs_mem52", dmem[13], 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
